// File: rtl/lmb_bram_port_cntlr.sv
// Single-outstanding valid/ready to BRAM port initiator with address-window decode.
// Four-state sequence per request: IDLE -> ACCESS -> CAPTURE -> RESP.
module lmb_bram_port_cntlr #(
  parameter int                  C_AWIDTH   = 32,
  parameter int                  C_DWIDTH   = 32,
  parameter int                  C_NUM_WE   = C_DWIDTH / 8,
  parameter logic [0:C_AWIDTH-1] C_BASEADDR = 32'h0000_0000,
  parameter logic [0:C_AWIDTH-1] C_HIGHADDR = 32'h0000_FFFF
) (
  input  logic                LMB_Clk,
  input  logic                LMB_Rst_N,
  input  logic                Req_Valid,
  output logic                Req_Ready,
  input  logic [0:C_AWIDTH-1] Req_Addr,
  input  logic                Req_Write,
  input  logic [0:C_NUM_WE-1] Req_BE,
  input  logic [0:C_DWIDTH-1] Req_WrData,
  output logic                Rsp_Valid,
  input  logic                Rsp_Ready,
  output logic [0:C_DWIDTH-1] Rsp_RdData,
  output logic                Rsp_Err,
  output logic                BRAM_Rst,
  output logic                BRAM_EN,
  output logic [0:C_NUM_WE-1] BRAM_WEN,
  output logic [0:C_AWIDTH-1] BRAM_Addr,
  output logic [0:C_DWIDTH-1] BRAM_Dout,
  input  logic [0:C_DWIDTH-1] BRAM_Din
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  // Offset from the base is computed one bit wider so addresses below the base
  // wrap to a huge value and fail the single upper-bound compare.
  localparam logic [C_AWIDTH:0] WIN_SPAN = {1'b0, C_HIGHADDR} - {1'b0, C_BASEADDR};

  state_t                state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [0:C_DWIDTH-1]   rsp_rddata_q;
  logic                  rsp_err_q;
  logic                  bram_rst_q;
  logic                  bram_en_q;
  logic [0:C_NUM_WE-1]   bram_wen_q;
  logic [0:C_AWIDTH-1]   bram_addr_q;
  logic [0:C_DWIDTH-1]   bram_dout_q;
  logic                  in_win_q;
  logic                  write_q;

  logic [C_AWIDTH:0]     addr_off_s;
  logic                  in_win_s;

  assign addr_off_s = {1'b0, Req_Addr} - {1'b0, C_BASEADDR};
  assign in_win_s   = (addr_off_s <= WIN_SPAN);

  // Transaction sequencer; every output is a register updated here.
  always_ff @(posedge LMB_Clk) begin
    if (!LMB_Rst_N) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rddata_q <= '0;
      rsp_err_q    <= 1'b0;
      bram_rst_q   <= 1'b1;
      bram_en_q    <= 1'b0;
      bram_wen_q   <= '0;
      bram_addr_q  <= '0;
      bram_dout_q  <= '0;
      in_win_q     <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      bram_rst_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Req_Valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            in_win_q    <= in_win_s;
            write_q     <= Req_Write;
            bram_en_q   <= in_win_s;
            bram_wen_q  <= (in_win_s && Req_Write) ? Req_BE : '0;
            // Out-of-window requests leave the BRAM address/data lines untouched.
            if (in_win_s) begin
              bram_addr_q <= {Req_Addr[0:C_AWIDTH-3], 2'b00};
              bram_dout_q <= Req_WrData;
            end
            state_q <= S_ACCESS;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_ACCESS: begin
          bram_en_q  <= 1'b0;
          bram_wen_q <= '0;
          state_q    <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rsp_rddata_q <= (in_win_q && !write_q) ? BRAM_Din : '0;
          rsp_err_q    <= !in_win_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (Rsp_Ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Req_Ready  = req_ready_q;
  assign Rsp_Valid  = rsp_valid_q;
  assign Rsp_RdData = rsp_rddata_q;
  assign Rsp_Err    = rsp_err_q;
  assign BRAM_Rst   = bram_rst_q;
  assign BRAM_EN    = bram_en_q;
  assign BRAM_WEN   = bram_wen_q;
  assign BRAM_Addr  = bram_addr_q;
  assign BRAM_Dout  = bram_dout_q;

endmodule

// File: tb/tb_lmb_bram_port_cntlr.sv
// Directed self-checking bench for lmb_bram_port_cntlr with a behavioural
// 64 KiB BRAM (read-first, byte writes, data out one cycle after the EN edge).
module tb_lmb_bram_port_cntlr;

  logic        clk = 1'b0;
  logic        LMB_Rst_N;
  logic        Req_Valid;
  logic        Req_Ready;
  logic [0:31] Req_Addr;
  logic        Req_Write;
  logic [0:3]  Req_BE;
  logic [0:31] Req_WrData;
  logic        Rsp_Valid;
  logic        Rsp_Ready;
  logic [0:31] Rsp_RdData;
  logic        Rsp_Err;
  logic        BRAM_Rst;
  logic        BRAM_EN;
  logic [0:3]  BRAM_WEN;
  logic [0:31] BRAM_Addr;
  logic [0:31] BRAM_Dout;
  logic [0:31] BRAM_Din;

  int checks = 0;
  int errors = 0;
  int en_count = 0;

  logic [0:31] mem [0:16383];

  always #5 clk = ~clk;

  lmb_bram_port_cntlr dut (
    .LMB_Clk    (clk),
    .LMB_Rst_N  (LMB_Rst_N),
    .Req_Valid  (Req_Valid),
    .Req_Ready  (Req_Ready),
    .Req_Addr   (Req_Addr),
    .Req_Write  (Req_Write),
    .Req_BE     (Req_BE),
    .Req_WrData (Req_WrData),
    .Rsp_Valid  (Rsp_Valid),
    .Rsp_Ready  (Rsp_Ready),
    .Rsp_RdData (Rsp_RdData),
    .Rsp_Err    (Rsp_Err),
    .BRAM_Rst   (BRAM_Rst),
    .BRAM_EN    (BRAM_EN),
    .BRAM_WEN   (BRAM_WEN),
    .BRAM_Addr  (BRAM_Addr),
    .BRAM_Dout  (BRAM_Dout),
    .BRAM_Din   (BRAM_Din)
  );

  // BRAM model: samples EN/WEN on the shared clock edge
  always @(posedge clk) begin
    if (BRAM_EN) begin
      en_count <= en_count + 1;
      BRAM_Din <= mem[BRAM_Addr[16:29]];
      for (int b = 0; b < 4; b++) begin
        if (BRAM_WEN[b]) mem[BRAM_Addr[16:29]][8*b +: 8] <= BRAM_Dout[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "/req_ready"}, Req_Ready, 0);
    chk({tag, "/rsp_valid"}, Rsp_Valid, 0);
    chk({tag, "/rsp_err"},   Rsp_Err, 0);
    chk({tag, "/rsp_rd"},    Rsp_RdData, 0);
    chk({tag, "/en"},        BRAM_EN, 0);
    chk({tag, "/wen"},       BRAM_WEN, 0);
    chk({tag, "/addr"},      BRAM_Addr, 0);
    chk({tag, "/dout"},      BRAM_Dout, 0);
    chk({tag, "/bram_rst"},  BRAM_Rst, 1);
  endtask

  // One full transaction, sampled on falling edges; stall = cycles Rsp_Ready is held low.
  task automatic xact(input string tag, input logic wr, input logic [0:31] addr,
                      input logic [0:3] be, input logic [0:31] wd, input logic exp_en,
                      input logic [0:31] exp_rd, input logic exp_err, input int stall);
    logic [0:31] al;
    int          en0;
    al = {addr[0:29], 2'b00};
    for (int i = 0; i < 8 && Req_Ready !== 1'b1; i++) @(negedge clk);
    chk({tag, "/ready_before"}, Req_Ready, 1);
    en0 = en_count;
    Req_Valid = 1'b1; Req_Write = wr; Req_Addr = addr; Req_BE = be; Req_WrData = wd;
    Rsp_Ready = 1'b0;
    @(negedge clk);
    Req_Valid = 1'b0; Req_Addr = 32'hFFFF_FFFF; Req_WrData = ~wd; Req_BE = 4'hF;
    chk({tag, "/t1_en"}, BRAM_EN, exp_en);
    chk({tag, "/t1_wen"}, BRAM_WEN, (exp_en && wr) ? be : 4'h0);
    chk({tag, "/t1_ready"}, Req_Ready, 0);
    if (exp_en) chk({tag, "/t1_addr"}, BRAM_Addr, al);
    if (exp_en && wr) chk({tag, "/t1_dout"}, BRAM_Dout, wd);
    @(negedge clk);
    chk({tag, "/t2_en"}, BRAM_EN, 0);
    chk({tag, "/t2_wen"}, BRAM_WEN, 0);
    chk({tag, "/t2_valid"}, Rsp_Valid, 0);
    @(negedge clk);
    chk({tag, "/t3_valid"}, Rsp_Valid, 1);
    chk({tag, "/t3_rd"}, Rsp_RdData, exp_rd);
    chk({tag, "/t3_err"}, Rsp_Err, exp_err);
    chk({tag, "/t3_ready"}, Req_Ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "/stall_valid"}, Rsp_Valid, 1);
      chk({tag, "/stall_rd"}, Rsp_RdData, exp_rd);
      chk({tag, "/stall_err"}, Rsp_Err, exp_err);
      chk({tag, "/stall_ready"}, Req_Ready, 0);
    end
    Rsp_Ready = 1'b1;
    @(negedge clk);
    Rsp_Ready = 1'b0;
    chk({tag, "/post_valid"}, Rsp_Valid, 0);
    chk({tag, "/post_ready"}, Req_Ready, 1);
    chk({tag, "/en_pulses"}, en_count - en0, exp_en);
  endtask

  logic [0:31] b2b_addr [0:2];
  logic [0:31] b2b_exp  [0:2];
  int          k, rsp_n, last_en;

  initial begin
    LMB_Rst_N = 1'b0; Req_Valid = 1'b0; Req_Addr = 32'h0; Req_Write = 1'b0;
    Req_BE = 4'h0; Req_WrData = 32'h0; Rsp_Ready = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    LMB_Rst_N = 1'b1;
    #1 chk("reset/ready_before_edge", Req_Ready, 0);
    @(negedge clk);
    chk("reset/ready_after_edge", Req_Ready, 1);
    chk("reset/bram_rst_released", BRAM_Rst, 0);

    xact("wr_dead",  1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 0);
    xact("rd_dead",  1'b0, 32'h0000_0010, 4'h0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 0);
    xact("wr_full",  1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 1'b1, 32'h0, 1'b0, 0);
    xact("wr_byte1", 1'b1, 32'h0000_0020, 4'b0100, 32'hAABB_CCDD, 1'b1, 32'h0, 1'b0, 0);
    xact("rd_merge", 1'b0, 32'h0000_0020, 4'h0, 32'h0,         1'b1, 32'h11BB_3344, 1'b0, 0);
    // 0xFFFE aligns down to 0xFFFC, the top word of the window
    xact("wr_misal", 1'b1, 32'h0000_FFFE, 4'hF, 32'h0BAD_CAFE, 1'b1, 32'h0, 1'b0, 0);
    xact("rd_top",   1'b0, 32'h0000_FFFC, 4'h0, 32'h0,         1'b1, 32'h0BAD_CAFE, 1'b0, 0);
    xact("rd_oow",   1'b0, 32'h0001_0000, 4'h0, 32'h0,         1'b0, 32'h0, 1'b1, 0);
    xact("wr_oow",   1'b1, 32'h0001_0004, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 1'b1, 0);
    xact("wr_be0",   1'b1, 32'h0000_0010, 4'h0, 32'h0000_0000, 1'b1, 32'h0, 1'b0, 0);
    xact("rd_stall", 1'b0, 32'h0000_0010, 4'h0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 5);

    // Back-to-back reads with Req_Valid and Rsp_Ready held high
    b2b_addr[0] = 32'h0000_0010; b2b_exp[0] = 32'hDEAD_BEEF;
    b2b_addr[1] = 32'h0000_0020; b2b_exp[1] = 32'h11BB_3344;
    b2b_addr[2] = 32'h0000_FFFC; b2b_exp[2] = 32'h0BAD_CAFE;
    k = 0; rsp_n = 0; last_en = -1;
    Req_Write = 1'b0; Req_BE = 4'h0; Req_Addr = b2b_addr[0];
    Req_Valid = 1'b1; Rsp_Ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (BRAM_EN) begin
        if (last_en >= 0) chk("b2b/en_spacing", c - last_en, 4);
        last_en = c;
        k++;
        if (k < 3) Req_Addr = b2b_addr[k];
        else Req_Valid = 1'b0;
      end
      if (Rsp_Valid) begin
        if (rsp_n < 3) begin
          chk("b2b/rsp_data", Rsp_RdData, b2b_exp[rsp_n]);
          chk("b2b/rsp_err", Rsp_Err, 0);
        end
        rsp_n++;
      end
    end
    Rsp_Ready = 1'b0;
    chk("b2b/requests", k, 3);
    chk("b2b/responses", rsp_n, 3);

    // Reset asserted during the ACCESS cycle of a write
    for (int i = 0; i < 8 && Req_Ready !== 1'b1; i++) @(negedge clk);
    chk("rst_mid/ready_before", Req_Ready, 1);
    Req_Valid = 1'b1; Req_Write = 1'b1; Req_Addr = 32'h0000_0020;
    Req_BE = 4'hF; Req_WrData = 32'h5566_7788;
    @(negedge clk);
    Req_Valid = 1'b0;
    chk("rst_mid/access_en", BRAM_EN, 1);
    chk("rst_mid/access_wen", BRAM_WEN, 4'hF);
    LMB_Rst_N = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid/no_rsp", Rsp_Valid, 0);
    end
    LMB_Rst_N = 1'b1;
    @(negedge clk);
    chk("rst_mid/ready_after", Req_Ready, 1);
    chk("rst_mid/bram_rst_low", BRAM_Rst, 0);
    chk("rst_mid/no_rsp_after", Rsp_Valid, 0);
    // EN/WEN were high throughout ACCESS, so the BRAM sampled the write on the reset edge
    xact("rd_after_rst", 1'b0, 32'h0000_0020, 4'h0, 32'h0, 1'b1, 32'h5566_7788, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
